bcd_serial_adder: RTL and testbench
===================================

// Module: bcd_serial_adder
// PURPOSE
//   Digit-serial multi-digit BCD adder; front end to the single-digit BCD adder stage.
//   Accepts two packed DIGITS-digit BCD operands and a carry-in over a valid/ready handshake.
//   Adds one decimal digit per cycle, LSD first, carrying between cycles.
//   Returns the packed BCD sum, the decimal carry-out and a sticky non-BCD-input error flag.
// PARAMETERS
//   DIGITS  4  number of BCD digits per operand (>=1); operand width W = 4*DIGITS
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   reset, asynchronous assert, active-low
//   in_valid   in   1   operand request valid
//   in_ready   out  1   block can accept an operand (high only in IDLE)
//   a          in   W   operand A, packed BCD, digit 0 in a[3:0]
//   b          in   W   operand B, packed BCD
//   cin        in   1   decimal carry-in to digit 0
//   out_valid  out  1   result valid (high only in DONE)
//   out_ready  in   1   consumer accepts result
//   sum        out  W   packed BCD sum
//   cout       out  1   decimal carry-out of the top digit
//   err        out  1   a or b contained a digit > 9 (sticky per operation)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, digit index=0, sum=0, cout=0, err=0, out_valid=0.
//     in_ready=1 once rst_n is released.
//     Reset mid-RUN or mid-DONE aborts the operation; no partial result is emitted.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: in_ready=1, out_valid=0. in_valid&in_ready at an edge captures a, b, cin.
//       On capture: idx=0, carry=cin, err=0, sum=0; go to RUN.
//       Inputs are ignored after capture.
//     RUN: in_ready=0, out_valid=0. Each edge processes digit idx:
//       z[4:0] = a_idx + b_idx + carry
//       if z>9: digit=(z+6)[3:0], carry=1
//       else:   digit=z[3:0],     carry=0
//       Write digit to sum[4*idx+:4]; err |= (a_idx>9)|(b_idx>9); idx++.
//       On the edge processing idx=DIGITS-1: cout=carry-out, go to DONE.
//     DONE: out_valid=1, in_ready=0. sum/cout/err held stable while out_ready=0.
//       out_valid&out_ready at an edge -> IDLE.
//   Latency: capture edge at cycle 0 -> out_valid high after edge DIGITS.
//     Throughput is one operation per DIGITS+2 cycles minimum.
//   Outputs are registered and keep the last result in IDLE until the next capture.
//   Non-BCD digits still follow the z>9 rule above (z<=31, no X); err flags them.
//   out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
//   No combinational path from in_valid/out_ready to any output.
// TESTING (DIGITS=4 unless stated)
//   a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, err=0;
//     out_valid rises exactly 4 cycles after capture.
//   a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all digits).
//   a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1, err=0.
//   a=0x00A0, b=0x0000, cin=0 -> sum=0x0100, cout=0, err=1.
//     Next clean op 0x0001+0x0001 -> err=0, sum=0x0002.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/sum stable, in_ready=0.
//     in_valid pulses are ignored.
//   Pulse rst_n low at RUN idx=2 -> outputs 0 immediately; next op 0x0005+0x0005 -> 0x0010.
//   Back-to-back ops with in_valid and out_ready held high -> one result per 6 cycles.
//     Results are correct; no op is lost or duplicated.
//   DIGITS=1: a=0x7, b=0x8 -> sum=0x5, cout=1, 1-cycle latency.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first, with a
// valid/ready operand handshake, registered result, decimal carry-out and sticky error.
module bcd_serial_adder #(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_err;

  logic [4:0]         w_z;
  logic               w_gt9;
  logic [3:0]         w_digit;
  logic               w_bad;
  logic               w_last;
  logic [W-1:0]       w_sum_next;

  // Operands are shifted right each RUN cycle, so the current digit is always [3:0].
  assign w_z     = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
  assign w_gt9   = (w_z > 5'd9);
  assign w_digit = w_gt9 ? 4'(w_z + 5'd6) : w_z[3:0];
  assign w_bad   = (r_a[3:0] > 4'd9) | (r_b[3:0] > 4'd9);
  assign w_last  = (r_idx == IDX_W'(DIGITS - 1));

  // NOTE: every signal driven in always_comb gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    w_sum_next = r_sum;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_idx == IDX_W'(d)) w_sum_next[4*d +: 4] = w_digit;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_gt9;
          r_sum   <= w_sum_next;
          r_err   <= r_err | w_bad;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) r_cout <= w_gt9;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode the registered state only, so no input reaches an output.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4 and DIGITS=1 instances).
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, err;
  logic [15:0] a, b, sum;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, err1;
  logic [3:0]  a1, b1, sum1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 4-digit instance with latency and result checks.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec, input logic ee);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_err"}, err, ee);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  logic [15:0] q_a [3] = '{16'h0012, 16'h0999, 16'h4321};
  logic [15:0] q_b [3] = '{16'h0034, 16'h0001, 16'h1234};
  logic [15:0] q_s [3] = '{16'h0046, 16'h1000, 16'h5555};

  initial begin
    int issued, got, cyc, last, extra;
    logic ir;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) tick();
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("ripple_9999_1", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("max_cin",       16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op("non_bcd",       16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
    run_op("err_clears",    16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    check("idle_holds_sum", sum, 16'h0002);

    // Backpressure: result must hold for 5 cycles while in_valid pulses are ignored.
    a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      a = 16'h1111; b = 16'h1111; in_valid = i[0];
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 16'h6912);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_sum_after", sum, 16'h6912);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", in_ready, 1);
    check("bp_held_idle", sum, 16'h6912);

    // Abort with async reset while digit index 2 is pending.
    run_op("pre_abort", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("abort_partial", sum, 16'h0012);
    rst_n = 1'b0;
    #1;
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("after_abort", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Back-to-back with both handshakes held high: one result per 6 cycles.
    issued = 0; got = 0; cyc = 0; last = 0;
    a = q_a[0]; b = q_b[0]; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      ir = in_ready;
      tick();
      cyc++;
      if (ir && in_valid) begin
        issued++;
        if (issued < 3) begin a = q_a[issued]; b = q_b[issued]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        check("b2b_sum", sum, q_s[got]);
        if (got > 0) check("b2b_period", cyc - last, 6);
        last = cyc;
        got++;
      end
    end
    check("b2b_count", got, 3);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) extra++;
    end
    check("b2b_no_dup", extra, 0);
    out_ready = 1'b0;

    // Single-digit instance: 7+8 = 15 -> digit 5, carry 1, after one RUN edge.
    a1 = 4'h7; b1 = 4'h8; cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("d1_not_yet", out_valid1, 0);
    tick();
    check("d1_valid", out_valid1, 1);
    check("d1_sum", sum1, 4'h5);
    check("d1_cout", cout1, 1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("d1_idle", in_ready1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
